// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer: FSM states,
// flag bit positions inside the {Z,C,V,N} flag word, and ALU select encodings.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_e;

  localparam int unsigned NUM_FLAGS = 4;

  localparam int unsigned FLG_Z = 3;
  localparam int unsigned FLG_C = 2;
  localparam int unsigned FLG_V = 1;
  localparam int unsigned FLG_N = 0;

  // S[2] selects the logic unit; S[1:0] picks the function inside each unit.
  localparam int unsigned OP_LOGIC_BIT = 2;
  localparam logic [2:0]  OP_ADD       = 3'b000;
  localparam logic [2:0]  OP_AND       = 3'b100;

  typedef logic [NUM_FLAGS-1:0] flags_t;

  // Flag word for a bypass load: only Zero and Negative carry meaning.
  function automatic flags_t load_flags(input logic is_zero, input logic msb);
    flags_t f;
    f        = '0;
    f[FLG_Z] = is_zero;
    f[FLG_N] = msb;
    return f;
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Control/register stage around an external combinational ALU: accepts commands,
// feeds the ALU from registers, writes back the result and flags, hands the result downstream.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned         DATA_W    = 8,
  parameter logic [DATA_W-1:0]   ACC_RESET = '0,
  parameter int unsigned         CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_operand,

  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_s,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_cout,
  input  logic              alu_ovf,
  input  logic              alu_neg,

  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [3:0]        res_flags,
  output logic [CNT_W-1:0]  op_count
);

  seq_state_e        state_q,   state_d;
  logic [DATA_W-1:0] acc_q,     acc_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [2:0]        op_q,      op_d;
  flags_t            flags_q,   flags_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d   = state_q;
    acc_d     = acc_q;
    operand_d = operand_q;
    op_d      = op_q;
    flags_d   = flags_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d      = cmd_op;
          operand_d = cmd_operand;
          if (cmd_load) begin
            acc_d   = cmd_operand;
            flags_d = load_flags(cmd_operand == '0, cmd_operand[DATA_W-1]);
            state_d = RESP;
          end else begin
            state_d = EXEC;
          end
        end
      end

      EXEC: begin
        acc_d          = alu_out;
        flags_d[FLG_Z] = alu_zero;
        flags_d[FLG_C] = alu_cout;
        flags_d[FLG_V] = alu_ovf;
        flags_d[FLG_N] = alu_neg;
        state_d        = RESP;
      end

      RESP: begin
        if (res_ready) begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= ACC_RESET;
      operand_q <= '0;
      op_q      <= '0;
      flags_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      operand_q <= operand_d;
      op_q      <= op_d;
      flags_q   <= flags_d;
      cnt_q     <= cnt_d;
    end
  end

  // ALU inputs come straight from registers: no combinational path from cmd_* to the ALU.
  assign alu_a     = acc_q;
  assign alu_b     = operand_q;
  assign alu_s     = op_q;

  assign cmd_ready = (state_q == IDLE);
  assign res_valid = (state_q == RESP);
  assign res_data  = acc_q;
  assign res_flags = flags_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a behavioural ALU (add / and) closes the loop,
// a second instance with a 2-bit counter and non-zero accumulator reset runs in lockstep.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_load, res_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_operand;

  logic        cmd_ready, res_valid;
  logic [7:0]  alu_a, alu_b, alu_out, res_data;
  logic [2:0]  alu_s;
  logic        alu_zero, alu_cout, alu_ovf, alu_neg;
  logic [3:0]  res_flags;
  logic [15:0] op_count;

  logic        cmd_ready2, res_valid2;
  logic [7:0]  alu_a2, alu_b2, alu_out2, res_data2;
  logic [2:0]  alu_s2;
  logic        alu_zero2, alu_cout2, alu_ovf2, alu_neg2;
  logic [3:0]  res_flags2;
  logic [1:0]  op_count2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_op(cmd_op), .cmd_operand(cmd_operand),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_out(alu_out),
    .alu_zero(alu_zero), .alu_cout(alu_cout), .alu_ovf(alu_ovf), .alu_neg(alu_neg),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_flags(res_flags), .op_count(op_count)
  );

  alu_op_sequencer #(.DATA_W(8), .ACC_RESET(8'hA5), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2), .cmd_load(cmd_load),
    .cmd_op(cmd_op), .cmd_operand(cmd_operand),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_s(alu_s2), .alu_out(alu_out2),
    .alu_zero(alu_zero2), .alu_cout(alu_cout2), .alu_ovf(alu_ovf2), .alu_neg(alu_neg2),
    .res_valid(res_valid2), .res_ready(res_ready), .res_data(res_data2),
    .res_flags(res_flags2), .op_count(op_count2)
  );

  // Reference ALU: returns {out, Z, C, V, N}.
  function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] s);
    logic [8:0] sum;
    logic [7:0] o;
    logic       c, v;
    sum = 9'd0; o = 8'd0; c = 1'b0; v = 1'b0;
    if (s == 3'b000) begin
      sum = {1'b0, a} + {1'b0, b};
      o   = sum[7:0];
      c   = sum[8];
      v   = (a[7] == b[7]) && (o[7] != a[7]);
    end else if (s == 3'b100) begin
      o = a & b;
    end
    return {o, (o == 8'd0), c, v, o[7]};
  endfunction

  always_comb {alu_out,  alu_zero,  alu_cout,  alu_ovf,  alu_neg}  = alu_model(alu_a,  alu_b,  alu_s);
  always_comb {alu_out2, alu_zero2, alu_cout2, alu_ovf2, alu_neg2} = alu_model(alu_a2, alu_b2, alu_s2);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command from a negedge, measure accept->res_valid latency in cycles,
  // check the result, and optionally complete the response handshake.
  task automatic do_cmd(input string tag, input logic ld, input logic [2:0] op,
                        input logic [7:0] opnd, input logic [7:0] exp_data,
                        input logic [3:0] exp_flags, input int exp_lat,
                        input logic collect, input logic chk2);
    int lat;
    check({tag, ".cmd_ready"}, cmd_ready, 1);
    cmd_valid   = 1'b1;
    cmd_load    = ld;
    cmd_op      = op;
    cmd_operand = opnd;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"},   lat,       exp_lat);
    check({tag, ".res_valid"}, res_valid, 1);
    check({tag, ".res_data"},  res_data,  exp_data);
    check({tag, ".res_flags"}, res_flags, exp_flags);
    if (chk2) begin
      check({tag, ".res_valid2"}, res_valid2, 1);
      check({tag, ".res_data2"},  res_data2,  exp_data);
    end
    if (collect) begin
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      check({tag, ".done_idle"}, cmd_ready, 1);
      check({tag, ".done_nores"}, res_valid, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; res_ready = 1'b0;
    cmd_op = 3'b000; cmd_operand = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: reset state
    check("rst.res_valid", res_valid, 0);
    check("rst.cmd_ready", cmd_ready, 1);
    check("rst.alu_a",     alu_a,     8'h00);
    check("rst.op_count",  op_count,  0);
    check("rst.alu_a2",    alu_a2,    8'hA5);
    check("rst.cmd_ready2", cmd_ready2, 1);

    // 2: signed overflow on add
    do_cmd("t2.load", 1'b1, OP_ADD, 8'h7F, 8'h7F, 4'b0000, 1, 1'b1, 1'b0);
    do_cmd("t2.add",  1'b0, OP_ADD, 8'h01, 8'h80, 4'b0011, 2, 1'b1, 1'b0);
    check("t2.op_count", op_count, 2);

    // 3: unsigned wrap to zero with carry
    do_cmd("t3.load", 1'b1, OP_ADD, 8'hFF, 8'hFF, 4'b0001, 1, 1'b1, 1'b0);
    do_cmd("t3.add",  1'b0, OP_ADD, 8'h01, 8'h00, 4'b1100, 2, 1'b1, 1'b0);
    check("t3.op_count", op_count, 4);

    // 4: logic op, then back-pressure with a competing command
    do_cmd("t4.load", 1'b1, OP_ADD, 8'hF0, 8'hF0, 4'b0001, 1, 1'b1, 1'b0);
    do_cmd("t4.and",  1'b0, OP_AND, 8'h0F, 8'h00, 4'b1000, 2, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_load = 1'b1; cmd_operand = 8'h55;
      @(posedge clk);
      @(negedge clk);
      check("t4.hold_valid", res_valid, 1);
      check("t4.hold_data",  res_data,  8'h00);
      check("t4.hold_flags", res_flags, 4'b1000);
      check("t4.hold_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check("t4.idle",     cmd_ready, 1);
    check("t4.acc_kept", alu_a,     8'h00);
    check("t4.op_count", op_count,  6);

    // 5: reset while the ALU op is executing
    do_cmd("t5.load", 1'b1, OP_ADD, 8'h33, 8'h33, 4'b0000, 1, 1'b1, 1'b0);
    check("t5.op_count_pre", op_count, 7);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = OP_ADD; cmd_operand = 8'h01;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("t5.in_exec", cmd_ready, 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("t5.cmd_ready", cmd_ready, 1);
    check("t5.acc",       alu_a,     8'h00);
    check("t5.acc2",      alu_a2,    8'hA5);
    check("t5.op_count",  op_count,  0);
    for (int i = 0; i < 3; i++) begin
      check("t5.no_res", res_valid, 0);
      @(negedge clk);
    end

    // 6: 2-bit counter saturates at 3
    begin
      logic [7:0] vals  [5] = '{8'h01, 8'h02, 8'h00, 8'h80, 8'h44};
      logic [3:0] flgs  [5] = '{4'b0000, 4'b0000, 4'b1000, 4'b0001, 4'b0000};
      logic [1:0] cnt2  [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      for (int i = 0; i < 5; i++) begin
        do_cmd("t6.load", 1'b1, OP_ADD, vals[i], vals[i], flgs[i], 1, 1'b1, 1'b1);
        check("t6.op_count",  op_count,  i + 1);
        check("t6.op_count2", op_count2, cnt2[i]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
